// File: rtl/video_pkg.sv
// Shared video timing constants and types for the 1280x1024@60 raster.
// Pixel-coordinate widths here must agree with wave_display_top's inputs.
// Contents: default porch/sync/active sizes, coordinate widths, sideband bundle.
package video_pkg;

  // Coordinate and counter widths
  localparam int X_W   = 11;
  localparam int Y_W   = 10;
  localparam int CNT_W = 11;
  localparam int FC_W  = 16;

  // Default 1280x1024@60 horizontal timing (pixels)
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 48;
  localparam int DEF_H_SYNC   = 112;
  localparam int DEF_H_BP     = 248;

  // Default 1280x1024@60 vertical timing (lines)
  localparam int DEF_V_ACTIVE = 1024;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 38;

  // Largest total that still fits an 11-bit position counter
  localparam int MAX_TOTAL = 2047;

  // Sideband bits carried alongside the pixel stream; sync bits are active-high here
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } vid_side_t;

  localparam int SIDE_W = $bits(vid_side_t);

  function automatic int span_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register used to align video sideband bits with a pipelined pixel path.
// Latency: DEPTH clocks, advancing every clock; no stall input, the consumer is clock-paced.
// Ports: clk, reset (async active-low, clears all stages), din[WIDTH], dout[WIDTH].
module sync_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // A zero-depth delay is a wire; callers bypass this module in that case.
  generate
    if (DEPTH < 1) begin : g_bad_depth
      $fatal(1, "sync_delay: DEPTH must be at least 1");
    end
    if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "sync_delay: WIDTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v position counters advanced by pix_en,
// registered (x, y, valid, vsync, frame_start, frame_count) one clock after the consuming edge,
// plus hsync_o/vsync_o/de_o delayed PIPE clocks (ungated by pix_en) to match the display path.
// Ports: clk, reset (async active-low), pix_en in; x[11], y[10], valid, vsync, frame_start,
// frame_count[16], hsync_o, vsync_o, de_o out.
module vga_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 1,
  parameter int PIPE     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pix_en,
  output logic [X_W-1:0]  x,
  output logic [Y_W-1:0]  y,
  output logic            valid,
  output logic            vsync,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            de_o
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Elaboration-time legality of the timing parameters
  generate
    if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
      $fatal(1, "vga_timing_gen: active area must be non-empty");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h_porch
      $fatal(1, "vga_timing_gen: horizontal porch and sync widths must be >= 1");
    end
    if (V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v_porch
      $fatal(1, "vga_timing_gen: vertical porch and sync widths must be >= 1");
    end
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2047");
    end
    if (V_ACTIVE > 1024) begin : g_bad_v_active
      $fatal(1, "vga_timing_gen: V_ACTIVE must not exceed 1024 (y is 10 bits)");
    end
    if (PIPE < 0 || PIPE > 7) begin : g_bad_pipe
      $fatal(1, "vga_timing_gen: PIPE must be in 0..7");
    end
  endgenerate

  // Region boundaries at counter width so comparisons are width-matched
  localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);

  // XOR mask that turns the internal active-high sync into the pin polarity
  localparam logic POL_INV = (SYNC_POL == 0);

  // h_cnt/v_cnt hold the position that the next pix_en edge will present
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic h_act;
  logic v_act;
  logic h_sync_now;
  logic v_sync_now;
  logic h_last;
  logic v_last;
  logic at_origin;

  always_comb begin
    h_act      = (h_cnt < H_ACT_C);
    v_act      = (v_cnt < V_ACT_C);
    h_sync_now = (h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI);
    v_sync_now = (v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI);
    h_last     = (h_cnt == H_LAST_C);
    v_last     = (v_cnt == V_LAST_C);
    at_origin  = (h_cnt == '0) && (v_cnt == '0);
  end

  // Position counters; the line counter only moves on the horizontal wrap,
  // so the (last,last) -> (0,0) double wrap happens in one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_last ? '0 : h_cnt + CNT_W'(1);
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
      end
    end
  end

  // Registered view of the position being presented
  logic hsync_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      valid       <= 1'b0;
      hsync_r     <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      // frame_start is a strobe: it must drop on hold cycles as well
      frame_start <= 1'b0;
      if (pix_en) begin
        x           <= h_act ? h_cnt : '0;
        y           <= v_act ? v_cnt[Y_W-1:0] : '0;
        valid       <= h_act && v_act;
        hsync_r     <= h_sync_now;
        vsync       <= v_sync_now;
        frame_start <= at_origin;
        if (at_origin) begin
          frame_count <= frame_count + FC_W'(1);
        end
      end
    end
  end

  // Sideband alignment pipe; runs every clock because the display path does
  vid_side_t side_now;
  vid_side_t side_dly;

  assign side_now = {hsync_r, vsync, valid};

  generate
    if (PIPE == 0) begin : g_no_pipe
      assign side_dly = side_now;
    end else begin : g_pipe
      sync_delay #(
        .DEPTH (PIPE),
        .WIDTH (SIDE_W)
      ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   (side_now),
        .dout  (side_dly)
      );
    end
  endgenerate

  // Polarity applied after the pipe so a cleared pipe reads as inactive sync
  assign hsync_o = side_dly.hsync ^ POL_INV;
  assign vsync_o = side_dly.vsync ^ POL_INV;
  assign de_o    = side_dly.de;

endmodule
